// File: rtl/sprite_motion_ctrl.sv
// Turns scaled joystick positions into clamped sprite motion once per video frame,
// and turns debounced fire presses into a valid/ready shot request with a frame cooldown.
module sprite_motion_ctrl #(
   parameter int H_MAX         = 640,
   parameter int V_MAX         = 480,
   parameter int SPRITE_W      = 32,
   parameter int SPRITE_H      = 32,
   parameter int CENTER_X      = 320,
   parameter int CENTER_Y      = 240,
   parameter int DEADZONE      = 24,
   parameter int SPEED_SHIFT   = 4,
   parameter int FIRE_COOLDOWN = 8,
   parameter int START_X       = 304,
   parameter int START_Y       = 224
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic [10:0] scaled_x,
   input  logic [10:0] scaled_y,
   input  logic        fire_tick,
   output logic [10:0] sprite_x,
   output logic [10:0] sprite_y,
   output logic        pos_valid,
   output logic        facing_left,
   output logic        shot_valid,
   input  logic        shot_ready,
   output logic [10:0] shot_x,
   output logic [10:0] shot_y
);

   localparam int CW = $clog2(FIRE_COOLDOWN + 1);
   localparam logic signed [12:0] X_LIMIT = 13'(H_MAX - SPRITE_W);
   localparam logic signed [12:0] Y_LIMIT = 13'(V_MAX - SPRITE_H);
   localparam logic signed [11:0] CX      = 12'(CENTER_X);
   localparam logic signed [11:0] CY      = 12'(CENTER_Y);
   localparam logic signed [11:0] DZ      = 12'(DEADZONE);
   localparam logic [10:0]        HALF_W  = 11'(SPRITE_W / 2);
   localparam logic [10:0]        HALF_H  = 11'(SPRITE_H / 2);

   typedef enum logic [1:0] {IDLE, SAMPLE, CALC, UPDATE} state_t;

   state_t            state, next_state;
   logic signed [11:0] off_x, off_y;
   logic signed [11:0] vel_x, vel_y;
   logic [CW-1:0]      cooldown;
   logic               fire_accept;

   // Any stick offset outside the deadzone must move at least one pixel,
   // even when the arithmetic shift rounds it to zero.
   function automatic logic signed [11:0] calc_vel(input logic signed [11:0] off);
      logic signed [11:0] mag;
      logic signed [11:0] v;
      mag = off[11] ? -off : off;
      v   = off >>> SPEED_SHIFT;
      if (mag <= DZ)
         v = 12'sd0;
      else if (v == 12'sd0)
         v = off[11] ? -12'sd1 : 12'sd1;
      return v;
   endfunction

   function automatic logic [10:0] clamp_pos(input logic [10:0] pos,
                                             input logic signed [11:0] vel,
                                             input logic signed [12:0] limit);
      logic signed [12:0] sum;
      sum = $signed({2'b00, pos}) + $signed({vel[11], vel});
      if (sum[12])
         return 11'd0;
      else if (sum > limit)
         return limit[10:0];
      else
         return sum[10:0];
   endfunction

   always_ff @(posedge clk) begin
      if (!reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (frame_tick) next_state = SAMPLE;
         SAMPLE:  next_state = CALC;
         CALC:    next_state = UPDATE;
         UPDATE:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Motion pipeline: one stage per FSM state, position registered on UPDATE.
   always_ff @(posedge clk) begin
      if (!reset) begin
         off_x       <= '0;
         off_y       <= '0;
         vel_x       <= '0;
         vel_y       <= '0;
         sprite_x    <= 11'(START_X);
         sprite_y    <= 11'(START_Y);
         pos_valid   <= 1'b0;
         facing_left <= 1'b0;
      end else begin
         pos_valid <= 1'b0;
         unique case (state)
            SAMPLE: begin
               off_x <= $signed({1'b0, scaled_x}) - CX;
               off_y <= $signed({1'b0, scaled_y}) - CY;
            end
            CALC: begin
               vel_x <= calc_vel(off_x);
               vel_y <= calc_vel(off_y);
            end
            UPDATE: begin
               sprite_x  <= clamp_pos(sprite_x, vel_x, X_LIMIT);
               sprite_y  <= clamp_pos(sprite_y, vel_y, Y_LIMIT);
               pos_valid <= 1'b1;
               if (vel_x != 12'sd0)
                  facing_left <= vel_x[11];
            end
            default: ;
         endcase
      end
   end

   assign fire_accept = fire_tick && !shot_valid && (cooldown == '0);

   // A completed handshake restarts the cooldown; presses that cannot be accepted are dropped.
   always_ff @(posedge clk) begin
      if (!reset) begin
         shot_valid <= 1'b0;
         shot_x     <= '0;
         shot_y     <= '0;
         cooldown   <= '0;
      end else if (shot_valid && shot_ready) begin
         shot_valid <= 1'b0;
         cooldown   <= CW'(FIRE_COOLDOWN);
      end else begin
         if (frame_tick && (cooldown != '0))
            cooldown <= cooldown - CW'(1);
         if (fire_accept) begin
            shot_valid <= 1'b1;
            shot_x     <= sprite_x + HALF_W;
            shot_y     <= sprite_y + HALF_H;
         end
      end
   end

endmodule
